// File: rtl/arith_pkg.sv
// Shared widths, arbiter state encoding and arith opcodes for the arith datapath.
// Constants only; no logic lives here.
package arith_pkg;

  localparam int DATA_W = 16;
  localparam int RES_W  = 32;
  localparam int OP_W   = 3;

  // Shift amount width used by OP_SHL; covers every bit position of the result.
  localparam int SHAMT_W = $clog2(RES_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes shared with the decoder; all results are RES_W wide, operands zero-extended.
  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_OR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_W-1:0] OP_CAT = 3'd7;

endpackage

// File: rtl/arith_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the result consumer.
// slave = arbiter side, master = requester/consumer side.
interface arith_arbiter_if;
  import arith_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [RES_W-1:0]  rsp_result;

  logic              busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/arith.sv
// Combinational arithmetic unit: RES_W result from two zero-extended DATA_W operands.
// Zero latency, no flow control; the caller registers inputs and output.
module arith
  import arith_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   opcode,
  output logic [RES_W-1:0]  outau
);

  logic [RES_W-1:0] a_x;
  logic [RES_W-1:0] b_x;

  assign a_x = {{(RES_W-DATA_W){1'b0}}, a};
  assign b_x = {{(RES_W-DATA_W){1'b0}}, b};

  always_comb begin
    outau = '0;
    case (opcode)
      OP_ADD:  outau = a_x + b_x;
      OP_SUB:  outau = a_x - b_x;
      OP_MUL:  outau = a_x * b_x;
      OP_AND:  outau = a_x & b_x;
      OP_OR:   outau = a_x | b_x;
      OP_XOR:  outau = a_x ^ b_x;
      OP_SHL:  outau = a_x << b[SHAMT_W-1:0];
      OP_CAT:  outau = {a, b};
      default: outau = '0;
    endcase
  end

endmodule

// File: rtl/arith_arbiter.sv
// Round-robin share of one arith unit between two requesters; accept->rsp_valid in 2 edges, 3 cycles/op.
// rsp_ready low parks the block in RESP and holds both request readies low.
module arith_arbiter
  import arith_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  arith_arbiter_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;

  logic              last_grant;
  logic              grant;
  logic              grant_id;
  logic              accept;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [OP_W-1:0]   op_code;
  logic [RES_W-1:0]  outau;

  logic              rsp_valid;
  logic              rsp_id;
  logic [RES_W-1:0]  rsp_result;

  // Tie goes to the port that did not win last time; a lone valid always wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          accept         = 1'b1;
          bus.req0_ready = ~grant;
          bus.req1_ready = grant;
          state_nxt      = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        op_a       <= grant ? bus.req1_a  : bus.req0_a;
        op_b       <= grant ? bus.req1_b  : bus.req0_b;
        op_code    <= grant ? bus.req1_op : bus.req0_op;
        grant_id   <= grant;
        last_grant <= grant;
      end
      case (state)
        EXEC: begin
          rsp_result <= outau;
          rsp_id     <= grant_id;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        IDLE: begin
          rsp_valid <= 1'b0;
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // The datapath only ever sees the latched operands, so requesters may change buses after acceptance.
  arith u_arith (
    .a      (op_a),
    .b      (op_b),
    .opcode (op_code),
    .outau  (outau)
  );

  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_result = rsp_result;
  assign bus.busy       = (state != IDLE);

endmodule
